// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotating active-low row drive, per-scan debounce FSM,
// and an 8-digit entry register for the 7-segment display.
module keypad_scanner #(
  parameter int SCAN_DIV  = 100000,
  parameter int DEB_SCANS = 20
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  COL,
  output logic [3:0]  ROW,
  output logic [3:0]  KEY,
  output logic        KEY_VALID,
  output logic        PRESSED,
  output logic [31:0] DIGITS
);

  localparam int               DIV_W     = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [7:0]       DEB_LIMIT = 8'(DEB_SCANS);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_e;

  logic [3:0]       colMeta_q, colSync_q;
  logic [DIV_W-1:0] divCnt_q;
  logic [3:0]       row_q;
  logic [1:0]       rowIdx_q;
  logic             scanSeen_q, scanMulti_q;
  logic [3:0]       scanCode_q;
  state_e           state_q;
  logic [7:0]       count_q;
  logic [3:0]       cand_q;
  logic [3:0]       key_q;
  logic             keyValid_q;
  logic             pressed_q;
  logic [31:0]      digits_q;

  logic             sampleNow, evalNow;
  logic [3:0]       colLow;
  logic             rowSingle, rowMulti;
  logic [1:0]       rowCol;
  logic             scanNone, scanSingle;
  logic [3:0]       scanCode;
  logic [7:0]       count_d;
  logic [31:0]      digits_d;

  function automatic logic [3:0] codeOf(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      default:  code = 4'hD;
    endcase
    return code;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      colMeta_q <= 4'hF;
      colSync_q <= 4'hF;
    end else begin
      colMeta_q <= COL;
      colSync_q <= colMeta_q;
    end
  end

  assign sampleNow = (divCnt_q == DIV_LAST);
  assign evalNow   = sampleNow && (rowIdx_q == 2'd3);

  // The row advances on the same edge its last settled column sample is taken.
  always_ff @(posedge CLK) begin
    if (RST) begin
      divCnt_q <= '0;
      row_q    <= 4'b1110;
      rowIdx_q <= 2'd0;
    end else if (sampleNow) begin
      divCnt_q <= '0;
      row_q    <= {row_q[2:0], row_q[3]};
      rowIdx_q <= rowIdx_q + 2'd1;
    end else begin
      divCnt_q <= divCnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    colLow    = ~colSync_q;
    rowSingle = 1'b0;
    rowMulti  = 1'b0;
    rowCol    = 2'd0;
    case (colLow)
      4'b0000: rowSingle = 1'b0;
      4'b0001: begin rowSingle = 1'b1; rowCol = 2'd0; end
      4'b0010: begin rowSingle = 1'b1; rowCol = 2'd1; end
      4'b0100: begin rowSingle = 1'b1; rowCol = 2'd2; end
      4'b1000: begin rowSingle = 1'b1; rowCol = 2'd3; end
      default: rowMulti = 1'b1;
    endcase
  end

  // Scan verdict combines the rows already seen with the row being sampled now.
  assign scanNone   = !scanSeen_q && !scanMulti_q && !rowSingle && !rowMulti;
  assign scanSingle = !scanMulti_q && !rowMulti && (scanSeen_q ^ rowSingle);
  assign scanCode   = scanSeen_q ? scanCode_q : codeOf(rowIdx_q, rowCol);

  always_ff @(posedge CLK) begin
    if (RST) begin
      scanSeen_q  <= 1'b0;
      scanMulti_q <= 1'b0;
      scanCode_q  <= 4'h0;
    end else if (evalNow) begin
      scanSeen_q  <= 1'b0;
      scanMulti_q <= 1'b0;
      scanCode_q  <= 4'h0;
    end else if (sampleNow) begin
      scanSeen_q  <= scanSeen_q | rowSingle;
      scanMulti_q <= scanMulti_q | rowMulti | (scanSeen_q & rowSingle);
      if (!scanSeen_q && rowSingle) begin
        scanCode_q <= codeOf(rowIdx_q, rowCol);
      end
    end
  end

  assign count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;

  always_comb begin
    digits_d = digits_q;
    if (cand_q <= 4'd9) begin
      digits_d = {digits_q[27:0], cand_q};
    end else if (cand_q == 4'hC) begin
      digits_d = 32'hFFFF_FFFF;
    end else if (cand_q == 4'hB) begin
      digits_d = {4'hF, digits_q[31:4]};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      count_q    <= 8'd0;
      cand_q     <= 4'h0;
      key_q      <= 4'h0;
      keyValid_q <= 1'b0;
      pressed_q  <= 1'b0;
      digits_q   <= 32'hFFFF_FFFF;
    end else begin
      keyValid_q <= 1'b0;
      if (evalNow) begin
        case (state_q)
          IDLE: begin
            if (scanSingle) begin
              cand_q  <= scanCode;
              count_q <= 8'd1;
              state_q <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (scanSingle && (scanCode == cand_q)) begin
              count_q <= count_d;
              if (count_d >= DEB_LIMIT) begin
                state_q    <= HELD;
                pressed_q  <= 1'b1;
                key_q      <= cand_q;
                keyValid_q <= 1'b1;
                digits_q   <= digits_d;
              end
            end else begin
              state_q <= IDLE;
            end
          end
          HELD: begin
            if (scanNone) begin
              count_q <= 8'd1;
              state_q <= RELEASE;
            end
          end
          RELEASE: begin
            if (scanNone) begin
              count_q <= count_d;
              if (count_d >= DEB_LIMIT) begin
                state_q   <= IDLE;
                pressed_q <= 1'b0;
              end
            end else begin
              state_q <= HELD;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ROW       = row_q;
  assign KEY       = key_q;
  assign KEY_VALID = keyValid_q;
  assign PRESSED   = pressed_q;
  assign DIGITS    = digits_q;

endmodule
